gppcu_thread_lane: RTL and testbench

GPPCU_THREAD_LANE -- requirements
Module: gppcu_thread_lane

---
 rtl/gppcu_thread_lane.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_gppcu_thread_lane.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gppcu_thread_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gppcu_thread_lane
// Purpose  : One thread lane. It runs a three-stage DEC->EXEC->WB pipeline
//            with a conditional ALU, {N,Z,C,V} status flags, a private local
//            memory and a handshake to an external multi-cycle (MC) unit.
// Ports    : iACLK/iRST            clock, synchronous active-high reset
//            iVALID/oREADY         instruction handshake at decode
//            iOPC..iLMRD           decoded instruction fields
//            iLMEM*/oLMEMRDATA     host port to local memory (1-cycle read)
//            oMC_*/iMC_DONE/iMC_Q  MC unit request and response
//            oSREG                 status flags {N,Z,C,V}
// Options  : `define GPPCU_THREAD_FWD_EN enables WB->DEC operand forwarding
// Revision : 1.0 - initial release
// ============================================================================
module gppcu_thread_lane #(
  parameter  int DBW     = 32,
  parameter  int NREG    = 32,
  parameter  int LMEM_AW = 11,
  localparam int RSW     = $clog2(NREG)
) (
  input  logic               iACLK,
  input  logic               iRST,
  input  logic               iVALID,
  output logic               oREADY,
  input  logic [3:0]         iOPC,
  input  logic               iMC,
  input  logic [3:0]         iCOND,
  input  logic               iSETS,
  input  logic [RSW-1:0]     iRA,
  input  logic [RSW-1:0]     iRB,
  input  logic [RSW-1:0]     iRD,
  input  logic [1:0]         iBSEL,
  input  logic [DBW-1:0]     iIMM,
  input  logic [DBW-1:0]     iGMEMDATA,
  input  logic               iREGWR,
  input  logic               iLMWR,
  input  logic               iLMRD,
  input  logic               iLMEMWREN,
  input  logic [LMEM_AW-1:0] iLMEMADDR,
  input  logic [DBW-1:0]     iLMEMWDATA,
  output logic [DBW-1:0]     oLMEMRDATA,
  output logic               oMC_START,
  output logic [3:0]         oMC_OPC,
  output logic [DBW-1:0]     oMC_A,
  output logic [DBW-1:0]     oMC_B,
  input  logic               iMC_DONE,
  input  logic [DBW-1:0]     iMC_Q,
  output logic [3:0]         oSREG
);

  localparam int SHW        = $clog2(DBW);
  localparam int LMEM_DEPTH = 1 << LMEM_AW;

  localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2,
                         OP_AND = 4'd3, OP_OR  = 4'd4, OP_XOR = 4'd5,
                         OP_SHL = 4'd6, OP_SHR = 4'd7, OP_ASR = 4'd8,
                         OP_MOV = 4'd9;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_START = 2'd1,
    MC_WAIT  = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_e;

  // Storage (never reset)
  logic [DBW-1:0] rf_q   [NREG];
  logic [DBW-1:0] lmem_q [LMEM_DEPTH];
  logic [DBW-1:0] host_rdata_q;

  // EXEC stage
  logic           ex_vld_q, ex_mc_q, ex_sets_q, ex_regwr_q, ex_lmwr_q, ex_lmrd_q;
  logic [3:0]     ex_opc_q, ex_cond_q;
  logic [RSW-1:0] ex_rd_q;
  logic [DBW-1:0] ex_a_q, ex_b_q;

  // WB stage
  logic           wb_vld_q, wb_regwr_q, wb_lmrd_q;
  logic [RSW-1:0] wb_rd_q;
  logic [DBW-1:0] wb_res_q, wb_lmdata_q;

  // Status and MC unit
  logic [3:0]     sreg_q;
  mc_state_e      state_q, state_d;
  logic [3:0]     mc_opc_q;
  logic [DBW-1:0] mc_a_q, mc_b_q, mc_res_q;

  logic           wb_we, cond_ok, mc_stall, lane_we;
  logic [DBW-1:0] wb_data, rd_a, rd_b, opb;
  logic [DBW-1:0] alu_q;
  logic           alu_c, alu_v;
  logic [LMEM_AW-1:0] lane_addr;

  assign wb_we   = wb_vld_q & wb_regwr_q;
  assign wb_data = wb_lmrd_q ? wb_lmdata_q : wb_res_q;

  // ---------------- DEC: operand read and B select ----------------
  always_comb begin
    rd_a = rf_q[iRA];
    rd_b = rf_q[iRB];
`ifdef GPPCU_THREAD_FWD_EN
    if (wb_we && (wb_rd_q == iRA)) rd_a = wb_data;
    if (wb_we && (wb_rd_q == iRB)) rd_b = wb_data;
`endif
    case (iBSEL)
      2'd0:    opb = rd_b;
      2'd1:    opb = rd_b + iIMM;
      2'd2:    opb = iIMM;
      default: opb = iGMEMDATA;
    endcase
  end

  // ---------------- EXEC: condition check ----------------
  logic f_n, f_z, f_c, f_v;
  assign {f_n, f_z, f_c, f_v} = sreg_q;

  always_comb begin
    cond_ok = 1'b0;
    case (ex_cond_q)
      4'd0:    cond_ok = 1'b1;
      4'd1:    cond_ok = f_z;
      4'd2:    cond_ok = ~f_z;
      4'd3:    cond_ok = f_c;
      4'd4:    cond_ok = ~f_c;
      4'd5:    cond_ok = f_n;
      4'd6:    cond_ok = ~f_n;
      4'd7:    cond_ok = f_v;
      4'd8:    cond_ok = ~f_v;
      4'd9:    cond_ok = f_c & ~f_z;
      4'd10:   cond_ok = ~f_c | f_z;
      4'd11:   cond_ok = (f_n == f_v);
      4'd12:   cond_ok = (f_n != f_v);
      4'd13:   cond_ok = ~f_z & (f_n == f_v);
      4'd14:   cond_ok = f_z | (f_n != f_v);
      default: cond_ok = 1'b0;
    endcase
  end

  // ---------------- EXEC: ALU ----------------
  // SUB is A + ~B + 1, so the carry out is the "no borrow" flag (A >= B).
  // Shifts run one bit wider so the last bit shifted out lands in bit DBW
  // (left) or bit 0 (right); a zero shift leaves C alone.
  logic [DBW-1:0]        b_op;
  logic                  cin;
  logic [DBW:0]          add_w, shl_w, shr_w;
  logic signed [DBW:0]   asr_w;
  logic [SHW-1:0]        sh;

  always_comb begin
    sh    = ex_b_q[SHW-1:0];
    b_op  = (ex_opc_q == OP_SUB) ? ~ex_b_q : ex_b_q;
    cin   = (ex_opc_q == OP_SUB) ? 1'b1 : ((ex_opc_q == OP_ADC) ? f_c : 1'b0);
    add_w = {1'b0, ex_a_q} + {1'b0, b_op} + {{DBW{1'b0}}, cin};
    shl_w = {1'b0, ex_a_q} << sh;
    shr_w = {ex_a_q, 1'b0} >> sh;
    asr_w = $signed({ex_a_q, 1'b0}) >>> sh;
    alu_q = ex_a_q;
    alu_c = f_c;
    alu_v = 1'b0;
    case (ex_opc_q)
      OP_ADD, OP_ADC, OP_SUB: begin
        alu_q = add_w[DBW-1:0];
        alu_c = add_w[DBW];
        alu_v = (ex_a_q[DBW-1] == b_op[DBW-1]) && (add_w[DBW-1] != ex_a_q[DBW-1]);
      end
      OP_AND: alu_q = ex_a_q & ex_b_q;
      OP_OR:  alu_q = ex_a_q | ex_b_q;
      OP_XOR: alu_q = ex_a_q ^ ex_b_q;
      OP_SHL: begin
        alu_q = shl_w[DBW-1:0];
        if (sh != '0) alu_c = shl_w[DBW];
      end
      OP_SHR: begin
        alu_q = shr_w[DBW:1];
        if (sh != '0) alu_c = shr_w[0];
      end
      OP_ASR: begin
        alu_q = asr_w[DBW:1];
        if (sh != '0) alu_c = asr_w[0];
      end
      OP_MOV:  alu_q = ex_b_q;
      default: alu_q = ex_a_q;
    endcase
  end

  // ---------------- MC FSM ----------------
  // A live MC op freezes DEC and EXEC until its DONE cycle, when it retires
  // into WB carrying the captured result.
  assign mc_stall = ex_vld_q & ex_mc_q & cond_ok & (state_q != MC_DONE);
  assign oREADY   = ~mc_stall;

  always_comb begin
    state_d   = state_q;
    oMC_START = 1'b0;
    case (state_q)
      MC_IDLE:  if (ex_vld_q && ex_mc_q && cond_ok) state_d = MC_START;
      MC_START: begin
        oMC_START = 1'b1;
        state_d   = MC_WAIT;
      end
      MC_WAIT:  if (iMC_DONE) state_d = MC_DONE;
      default:  state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge iACLK) begin
    if (iRST) begin
      state_q  <= MC_IDLE;
      mc_opc_q <= '0;
      mc_a_q   <= '0;
      mc_b_q   <= '0;
      mc_res_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MC_IDLE && state_d == MC_START) begin
        mc_opc_q <= ex_opc_q;
        mc_a_q   <= ex_a_q;
        mc_b_q   <= ex_b_q;
      end
      if (state_q == MC_WAIT && iMC_DONE) mc_res_q <= iMC_Q;
    end
  end

  assign oMC_OPC = mc_opc_q;
  assign oMC_A   = mc_a_q;
  assign oMC_B   = mc_b_q;

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge iACLK) begin
    if (iRST) begin
      ex_vld_q <= 1'b0;
      wb_vld_q <= 1'b0;
      sreg_q   <= '0;
    end else begin
      if (!mc_stall) ex_vld_q <= iVALID;
      wb_vld_q <= ex_vld_q & ~mc_stall;
      if (ex_vld_q && cond_ok && ex_sets_q && !mc_stall) begin
        if (ex_mc_q) sreg_q <= {mc_res_q[DBW-1], (mc_res_q == '0), f_c, f_v};
        else         sreg_q <= {alu_q[DBW-1], (alu_q == '0), alu_c, alu_v};
      end
    end
  end

  always_ff @(posedge iACLK) begin
    if (!mc_stall) begin
      ex_opc_q   <= iOPC;
      ex_mc_q    <= iMC;
      ex_cond_q  <= iCOND;
      ex_sets_q  <= iSETS;
      ex_rd_q    <= iRD;
      ex_regwr_q <= iREGWR;
      ex_lmwr_q  <= iLMWR;
      ex_lmrd_q  <= iLMRD;
      ex_a_q     <= rd_a;
      ex_b_q     <= opb;
    end
    wb_regwr_q <= ex_regwr_q & cond_ok;
    wb_lmrd_q  <= ex_lmrd_q;
    wb_rd_q    <= ex_rd_q;
    wb_res_q   <= ex_mc_q ? mc_res_q : alu_q;
    if (wb_we) rf_q[wb_rd_q] <= wb_data;
  end

  // ---------------- Local memory ----------------
  // The lane port wins a same-address collision; the host write is dropped.
  assign lane_addr = ex_b_q[LMEM_AW-1:0];
  assign lane_we   = ex_vld_q & cond_ok & ex_lmwr_q & ~mc_stall;

  always_ff @(posedge iACLK) begin
    if (lane_we) lmem_q[lane_addr] <= ex_a_q;
    if (iLMEMWREN && !(lane_we && (lane_addr == iLMEMADDR)))
      lmem_q[iLMEMADDR] <= iLMEMWDATA;
    host_rdata_q <= lmem_q[iLMEMADDR];
    wb_lmdata_q  <= lmem_q[lane_addr];
  end

  assign oLMEMRDATA = host_rdata_q;
  assign oSREG      = sreg_q;

endmodule
`default_nettype wire

// File: tb/tb_gppcu_thread_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gppcu_thread_lane
// Purpose  : Directed bench for gppcu_thread_lane: table of ALU vectors plus
//            hand-written sequences for conditions, local memory, MC and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gppcu_thread_lane;

  logic        clk, rst;
  logic        iVALID, oREADY, iMC, iSETS, iREGWR, iLMWR, iLMRD, iLMEMWREN;
  logic [3:0]  iOPC, iCOND, oMC_OPC, oSREG;
  logic [4:0]  iRA, iRB, iRD;
  logic [1:0]  iBSEL;
  logic [31:0] iIMM, iGMEMDATA, iLMEMWDATA, oLMEMRDATA, oMC_A, oMC_B, iMC_Q;
  logic [10:0] iLMEMADDR;
  logic        oMC_START, mc_done, done_auto, done_man, mc_auto;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  logic [31:0] cap_a, cap_b;
  logic [3:0]  cap_opc;

  assign mc_done = done_auto | done_man;

  gppcu_thread_lane #(.DBW(32), .NREG(32), .LMEM_AW(11)) dut (
    .iACLK(clk), .iRST(rst), .iVALID(iVALID), .oREADY(oREADY),
    .iOPC(iOPC), .iMC(iMC), .iCOND(iCOND), .iSETS(iSETS),
    .iRA(iRA), .iRB(iRB), .iRD(iRD), .iBSEL(iBSEL), .iIMM(iIMM),
    .iGMEMDATA(iGMEMDATA), .iREGWR(iREGWR), .iLMWR(iLMWR), .iLMRD(iLMRD),
    .iLMEMWREN(iLMEMWREN), .iLMEMADDR(iLMEMADDR), .iLMEMWDATA(iLMEMWDATA),
    .oLMEMRDATA(oLMEMRDATA), .oMC_START(oMC_START), .oMC_OPC(oMC_OPC),
    .oMC_A(oMC_A), .oMC_B(oMC_B), .iMC_DONE(mc_done), .iMC_Q(iMC_Q),
    .oSREG(oSREG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Start-pulse monitor
  always @(negedge clk) begin
    if (oMC_START) begin
      starts  = starts + 1;
      cap_a   = oMC_A;
      cap_b   = oMC_B;
      cap_opc = oMC_OPC;
    end
  end

  // MC responder: result valid six cycles after the start pulse
  initial begin
    done_auto = 1'b0;
    iMC_Q     = 32'h3F80_0000;
    forever begin
      @(negedge clk);
      if (oMC_START && mc_auto) begin
        repeat (6) @(posedge clk);
        #1 done_auto = 1'b1;
        @(posedge clk);
        #1 done_auto = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Present one instruction and hold it until accepted; returns rejected cycles.
  task automatic issue(input logic [3:0] opc, input logic mc, input logic [3:0] cond,
                       input logic sets, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rd, input logic [1:0] bsel, input logic [31:0] imm,
                       input logic regwr, input logic lmwr, input logic lmrd,
                       output int stalls);
    bit ok;
    iVALID = 1'b1; iOPC = opc; iMC = mc; iCOND = cond; iSETS = sets;
    iRA = ra; iRB = rb; iRD = rd; iBSEL = bsel; iIMM = imm;
    iREGWR = regwr; iLMWR = lmwr; iLMRD = lmrd;
    ok = 1'b0;
    stalls = 0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (oREADY) ok = 1'b1;
      else stalls = stalls + 1;
      @(posedge clk);
      #1;
    end
    iVALID = 1'b0; iMC = 1'b0; iSETS = 1'b0; iREGWR = 1'b0; iLMWR = 1'b0; iLMRD = 1'b0;
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL issue_accept actual=timeout required=accepted");
    end
  endtask

  task automatic op(input logic [3:0] opc, input logic [3:0] cond, input logic sets,
                    input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                    input logic [1:0] bsel, input logic [31:0] imm);
    int s;
    issue(opc, 1'b0, cond, sets, ra, rb, rd, bsel, imm, 1'b1, 1'b0, 1'b0, s);
  endtask

  task automatic mov_imm(input logic [4:0] rd, input logic [31:0] v);
    op(4'd9, 4'd0, 1'b0, 5'd0, 5'd0, rd, 2'd2, v);
  endtask

  task automatic host_wr(input logic [10:0] a, input logic [31:0] d);
    iLMEMWREN = 1'b1; iLMEMADDR = a; iLMEMWDATA = d;
    tick();
    iLMEMWREN = 1'b0;
  endtask

  task automatic host_rd(input logic [10:0] a, output logic [31:0] d);
    iLMEMADDR = a;
    tick();
    d = oLMEMRDATA;
  endtask

  // Observe a register through the ports: store it to local memory, read back.
  task automatic read_reg(input logic [4:0] r, output logic [31:0] d);
    int s;
    idle(3);
    issue(4'd9, 1'b0, 4'd0, 1'b0, r, 5'd0, 5'd0, 2'd2, 32'h3F0, 1'b0, 1'b1, 1'b0, s);
    idle(1);
    host_rd(11'h3F0, d);
  endtask

  typedef struct {
    logic [3:0]  opc;
    logic        pre_c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] d;
    int s, st0;

    vecs[0]  = '{4'd0,  1'b0, 32'd5,          32'd7,          32'd12,         4'b0000};
    vecs[1]  = '{4'd0,  1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0110};
    vecs[2]  = '{4'd0,  1'b0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b1001};
    vecs[3]  = '{4'd1,  1'b1, 32'd5,          32'd7,          32'd13,         4'b0000};
    vecs[4]  = '{4'd2,  1'b0, 32'd5,          32'd7,          32'hFFFF_FFFE,  4'b1000};
    vecs[5]  = '{4'd2,  1'b0, 32'd7,          32'd5,          32'd2,          4'b0010};
    vecs[6]  = '{4'd2,  1'b0, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  4'b0011};
    vecs[7]  = '{4'd3,  1'b1, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  4'b0010};
    vecs[8]  = '{4'd4,  1'b0, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  4'b0000};
    vecs[9]  = '{4'd5,  1'b0, 32'h0000_AAAA,  32'h0000_AAAA,  32'd0,          4'b0100};
    vecs[10] = '{4'd6,  1'b0, 32'h8000_0001,  32'd1,          32'd2,          4'b0010};
    vecs[11] = '{4'd7,  1'b0, 32'd3,          32'd1,          32'd1,          4'b0010};
    vecs[12] = '{4'd8,  1'b0, 32'h8000_0000,  32'd4,          32'hF800_0000,  4'b1000};
    vecs[13] = '{4'd9,  1'b1, 32'd5,          32'd9,          32'd9,          4'b0010};
    vecs[14] = '{4'd12, 1'b0, 32'd5,          32'd7,          32'd5,          4'b0000};

    iVALID = 0; iOPC = 0; iMC = 0; iCOND = 0; iSETS = 0; iRA = 0; iRB = 0; iRD = 0;
    iBSEL = 0; iIMM = 0; iGMEMDATA = 0; iREGWR = 0; iLMWR = 0; iLMRD = 0;
    iLMEMWREN = 0; iLMEMADDR = 0; iLMEMWDATA = 0; done_man = 0; mc_auto = 1;

    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("rst_ready", {31'd0, oREADY}, 32'd1);
    chk("rst_sreg", {28'd0, oSREG}, 32'd0);
    chk("rst_mc_start", {31'd0, oMC_START}, 32'd0);
    chk("rst_mc_a", oMC_A, 32'd0);
    chk("rst_mc_b", oMC_B, 32'd0);
    chk("rst_mc_opc", {28'd0, oMC_OPC}, 32'd0);

    // ALU table: R3 = R1 op R2 with flags; C preset by ADD #0 (C=0) / SUB #0 (C=1)
    for (int i = 0; i < 15; i++) begin
      mov_imm(5'd1, vecs[i].a);
      mov_imm(5'd2, vecs[i].b);
      op(vecs[i].pre_c ? 4'd2 : 4'd0, 4'd0, 1'b1, 5'd1, 5'd0, 5'd9, 2'd2, 32'd0);
      idle(3);
      op(vecs[i].opc, 4'd0, 1'b1, 5'd1, 5'd2, 5'd3, 2'd0, 32'd0);
      idle(2);
      chk($sformatf("alu%0d_flags", i), {28'd0, oSREG}, {28'd0, vecs[i].f});
      read_reg(5'd3, d);
      chk($sformatf("alu%0d_q", i), d, vecs[i].q);
    end

    // Conditional execution right after a flag-setting SUB
    mov_imm(5'd1, 32'd5);
    mov_imm(5'd6, 32'h55);
    idle(3);
    op(4'd2, 4'd0, 1'b1, 5'd1, 5'd1, 5'd4, 2'd0, 32'd0);
    op(4'd9, 4'd1, 1'b0, 5'd0, 5'd0, 5'd5, 2'd2, 32'd9);
    op(4'd9, 4'd2, 1'b0, 5'd0, 5'd0, 5'd6, 2'd2, 32'd3);
    idle(2);
    chk("cond_sreg", {28'd0, oSREG}, 32'b0110);
    read_reg(5'd5, d);
    chk("cond_eq_r5", d, 32'd9);
    read_reg(5'd6, d);
    chk("cond_ne_r6", d, 32'h55);

    // B select: regB+imm wraps, and global memory data
    mov_imm(5'd2, 32'hFFFF_FFF0);
    idle(3);
    op(4'd9, 4'd0, 1'b0, 5'd0, 5'd2, 5'd13, 2'd1, 32'h20);
    iGMEMDATA = 32'h5A5A_1234;
    op(4'd9, 4'd0, 1'b0, 5'd0, 5'd0, 5'd14, 2'd3, 32'd0);
    iGMEMDATA = 32'd0;
    read_reg(5'd13, d);
    chk("bsel_wrap", d, 32'h10);
    read_reg(5'd14, d);
    chk("bsel_gmem", d, 32'h5A5A_1234);

    // Local memory: host write / lane read, lane write / host read, collision
    host_wr(11'h7FF, 32'hDEAD_BEEF);
    issue(4'd9, 1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd7, 2'd2, 32'h7FF, 1'b1, 1'b0, 1'b1, s);
    read_reg(5'd7, d);
    chk("lmrd_r7", d, 32'hDEAD_BEEF);
    mov_imm(5'd8, 32'h1234);
    idle(3);
    issue(4'd9, 1'b0, 4'd0, 1'b0, 5'd8, 5'd0, 5'd0, 2'd2, 32'h10, 1'b0, 1'b1, 1'b0, s);
    host_wr(11'h10, 32'hCAFE_F00D);
    host_rd(11'h10, d);
    chk("lmwr_collision", d, 32'h1234);
    host_wr(11'h11, 32'hCAFE_F00D);
    host_rd(11'h11, d);
    chk("host_wr_rd", d, 32'hCAFE_F00D);

    // MC op followed by a waiting instruction
    mov_imm(5'd1, 32'h11);
    mov_imm(5'd2, 32'h22);
    idle(3);
    op(4'd2, 4'd0, 1'b1, 5'd1, 5'd0, 5'd9, 2'd2, 32'h12);
    starts = 0;
    issue(4'd3, 1'b1, 4'd0, 1'b1, 5'd1, 5'd2, 5'd10, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, s);
    issue(4'd0, 1'b0, 4'd0, 1'b0, 5'd1, 5'd0, 5'd11, 2'd2, 32'd1, 1'b1, 1'b0, 1'b0, s);
    idle(3);
    chk("mc_stall_cycles", s, 8);
    chk("mc_start_count", starts, 1);
    chk("mc_a", cap_a, 32'h11);
    chk("mc_b", cap_b, 32'h22);
    chk("mc_opc", {28'd0, cap_opc}, 32'd3);
    chk("mc_sreg", {28'd0, oSREG}, 32'd0);
    read_reg(5'd10, d);
    chk("mc_rd", d, 32'h3F80_0000);
    read_reg(5'd11, d);
    chk("mc_next_instr", d, 32'h12);

    // Reset while the MC FSM waits, then a stray done pulse
    mc_auto = 1'b0;
    mov_imm(5'd12, 32'h77);
    idle(3);
    st0 = starts;
    issue(4'd3, 1'b1, 4'd0, 1'b1, 5'd1, 5'd2, 5'd12, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, s);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    chk("rstmc_ready", {31'd0, oREADY}, 32'd1);
    chk("rstmc_mc_a", oMC_A, 32'd0);
    chk("rstmc_sreg", {28'd0, oSREG}, 32'd0);
    idle(3);
    chk("rstmc_ready_later", {31'd0, oREADY}, 32'd1);
    chk("rstmc_no_restart", starts, st0 + 1);
    read_reg(5'd12, d);
    chk("rstmc_no_write", d, 32'h77);
    read_reg(5'd1, d);
    chk("rstmc_rf_kept", d, 32'h11);
    mc_auto = 1'b1;

    // ADD R1,R1,#1 three times
    mov_imm(5'd1, 32'd0);
    idle(3);
`ifdef GPPCU_THREAD_FWD_EN
    op(4'd0, 4'd0, 1'b0, 5'd1, 5'd0, 5'd1, 2'd2, 32'd1);
    idle(1);
    op(4'd0, 4'd0, 1'b0, 5'd1, 5'd0, 5'd1, 2'd2, 32'd1);
    idle(1);
    op(4'd0, 4'd0, 1'b0, 5'd1, 5'd0, 5'd1, 2'd2, 32'd1);
    read_reg(5'd1, d);
    chk("fwd_inc3", d, 32'd3);
`else
    op(4'd0, 4'd0, 1'b0, 5'd1, 5'd0, 5'd1, 2'd2, 32'd1);
    op(4'd0, 4'd0, 1'b0, 5'd1, 5'd0, 5'd1, 2'd2, 32'd1);
    op(4'd0, 4'd0, 1'b0, 5'd1, 5'd0, 5'd1, 2'd2, 32'd1);
    read_reg(5'd1, d);
    chk("nofwd_inc_b2b", d, 32'd1);
`endif
    mov_imm(5'd1, 32'd0);
    idle(3);
    op(4'd0, 4'd0, 1'b0, 5'd1, 5'd0, 5'd1, 2'd2, 32'd1);
    idle(2);
    op(4'd0, 4'd0, 1'b0, 5'd1, 5'd0, 5'd1, 2'd2, 32'd1);
    idle(2);
    op(4'd0, 4'd0, 1'b0, 5'd1, 5'd0, 5'd1, 2'd2, 32'd1);
    read_reg(5'd1, d);
    chk("inc_spaced3", d, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
